router_credit_tx: RTL

Credit-based flit transmitter for one router output link: the sending end of the flit/link-credit interface that every router input port receives. It accepts flits from the switch-allocation/crossbar stage with a valid/ready handshake. It keeps one link-credit counter per virtual channel and only admits a flit when its VC holds a credit. Admitted flits are driven onto the link with a one-cycle-early pend indication, and returned credits are absorbed from the downstream receiver. One instance sits behind each router output port (N, S, E, W, local).

---
 rtl/router_credit_tx_pkg.sv | 23 ++
 rtl/router_credit_tx_if.sv | 28 ++
 rtl/router_credit_tx_vc_credit_counter.sv | 56 +++++
 rtl/router_credit_tx.sv | 127 ++++++++++++
 4 files changed

// File: rtl/router_credit_tx_pkg.sv
// Shared definitions for the credit-based flit link: payload type, VC id width
// and the credit counter width helper used by both link ends.
package router_credit_tx_pkg;

    localparam int LOCAL_PORT_NUM_MAX = 4;
    localparam int VC_NUM_MAX         = 1 + LOCAL_PORT_NUM_MAX;
    localparam int VC_ID_NUM_MAX_W    = $clog2(VC_NUM_MAX);
    localparam int FLIT_PAYLOAD_W     = 256;

    typedef logic [FLIT_PAYLOAD_W-1:0] flit_payload_t;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_DEC  = 2'd1,
        CNT_INC  = 2'd2
    } cnt_op_e;

    // Bits needed to hold 0..max_credit inclusive.
    function automatic int credit_w(input int max_credit);
        return (max_credit < 1) ? 1 : $clog2(max_credit + 1);
    endfunction

endpackage

// File: rtl/router_credit_tx_if.sv
// Flit request handshake plus the outgoing flit/link-credit channel of one
// router output port. master = transmitter, slave = crossbar stage + receiver.
interface router_credit_tx_if #(
    parameter int FLIT_W  = 256,
    parameter int VC_ID_W = 3
);
    logic               req_v_i;
    logic [FLIT_W-1:0]  req_flit_i;
    logic [VC_ID_W-1:0] req_vc_id_i;
    logic               req_rdy_o;
    logic               tx_flit_pend_o;
    logic               tx_flit_v_o;
    logic [FLIT_W-1:0]  tx_flit_o;
    logic [VC_ID_W-1:0] tx_flit_vc_id_o;
    logic               tx_lcrd_v_i;
    logic [VC_ID_W-1:0] tx_lcrd_id_i;

    modport master (
        input  req_v_i, req_flit_i, req_vc_id_i, tx_lcrd_v_i, tx_lcrd_id_i,
        output req_rdy_o, tx_flit_pend_o, tx_flit_v_o, tx_flit_o, tx_flit_vc_id_o
    );

    modport slave (
        output req_v_i, req_flit_i, req_vc_id_i, tx_lcrd_v_i, tx_lcrd_id_i,
        input  req_rdy_o, tx_flit_pend_o, tx_flit_v_o, tx_flit_o, tx_flit_vc_id_o
    );

endinterface

// File: rtl/router_credit_tx_vc_credit_counter.sv
// Link-credit counter for one VC: starts full, decremented on flit accept,
// incremented on credit return, saturating at MAX with an overflow strobe.
module vc_credit_counter
    import router_credit_tx_pkg::*;
#(
    parameter int MAX = 4,
    parameter int CW  = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dec,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          nonzero,
    output logic          ovf
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX);

    cnt_op_e       op_s;
    logic [CW-1:0] cnt_r;

    // Simultaneous inc and dec cancel out.
    always_comb begin
        op_s = CNT_HOLD;
        case ({inc, dec})
            2'b10:   op_s = CNT_INC;
            2'b01:   op_s = CNT_DEC;
            default: op_s = CNT_HOLD;
        endcase
    end

    // Counter register, saturating at both ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= MAX_C;
        end else begin
            case (op_s)
                CNT_INC: begin
                    if (cnt_r != MAX_C) cnt_r <= cnt_r + CW'(1);
                    else                cnt_r <= cnt_r;
                end
                CNT_DEC: begin
                    if (cnt_r != {CW{1'b0}}) cnt_r <= cnt_r - CW'(1);
                    else                     cnt_r <= cnt_r;
                end
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign cnt     = cnt_r;
    assign nonzero = (cnt_r != {CW{1'b0}});
    assign ovf     = (op_s == CNT_INC) && (cnt_r == MAX_C);

endmodule

// File: rtl/router_credit_tx.sv
// Credit-based flit transmitter for one router output link: per-VC credit
// gating of the request handshake and a two-stage pend/valid output pipeline.
module router_credit_tx
    import router_credit_tx_pkg::*;
#(
    parameter  int VC_NUM        = 2,
    parameter  int VC_ID_W       = VC_ID_NUM_MAX_W,
    parameter  int FLIT_W        = FLIT_PAYLOAD_W,
    parameter  int CREDIT_PER_VC = 4,
    localparam int CW            = credit_w(CREDIT_PER_VC)
) (
    input  logic                 clk,
    input  logic                 rstn,
    router_credit_tx_if.master   link,
    output logic [VC_NUM*CW-1:0] credit_cnt_o,
    output logic                 err_o
);

    localparam logic [VC_ID_W:0] VC_NUM_L = (VC_ID_W + 1)'(VC_NUM);

    logic [VC_NUM-1:0]  nonzero_s;
    logic [VC_NUM-1:0]  ovf_s;
    logic [VC_NUM-1:0]  dec_s;
    logic [VC_NUM-1:0]  inc_s;
    logic               req_vc_ok_s;
    logic               sel_nonzero_s;
    logic               rdy_s;
    logic               accept_s;
    logic               ret_bad_s;

    logic               s1_v_r;
    logic [FLIT_W-1:0]  s1_flit_r;
    logic [VC_ID_W-1:0] s1_vc_r;
    logic               s2_v_r;
    logic [FLIT_W-1:0]  s2_flit_r;
    logic [VC_ID_W-1:0] s2_vc_r;
    logic               err_r;

    // Ready mux: only registered counters feed it, so a same-cycle return
    // cannot raise ready.
    always_comb begin
        sel_nonzero_s = 1'b0;
        for (int i = 0; i < VC_NUM; i++) begin
            sel_nonzero_s = (link.req_vc_id_i == VC_ID_W'(i)) ? nonzero_s[i] : sel_nonzero_s;
        end
        req_vc_ok_s = ({1'b0, link.req_vc_id_i} < VC_NUM_L);
        rdy_s       = req_vc_ok_s & sel_nonzero_s;
        accept_s    = link.req_v_i & rdy_s;
        ret_bad_s   = link.tx_lcrd_v_i & ({1'b0, link.tx_lcrd_id_i} >= VC_NUM_L);
    end

    for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
        assign dec_s[g] = accept_s & (link.req_vc_id_i == VC_ID_W'(g));
        assign inc_s[g] = link.tx_lcrd_v_i & (link.tx_lcrd_id_i == VC_ID_W'(g));

        vc_credit_counter #(
            .MAX (CREDIT_PER_VC),
            .CW  (CW)
        ) u_cnt (
            .clk     (clk),
            .rst_n   (rstn),
            .dec     (dec_s[g]),
            .inc     (inc_s[g]),
            .cnt     (credit_cnt_o[g*CW +: CW]),
            .nonzero (nonzero_s[g]),
            .ovf     (ovf_s[g])
        );
    end

    // Stage valids: in-flight flits are dropped on reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_v_r <= 1'b0;
            s2_v_r <= 1'b0;
        end else begin
            s1_v_r <= accept_s;
            s2_v_r <= s1_v_r;
        end
    end

    // Stage 1 data loads only on accept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_flit_r <= {FLIT_W{1'b0}};
            s1_vc_r   <= {VC_ID_W{1'b0}};
        end else if (accept_s) begin
            s1_flit_r <= link.req_flit_i;
            s1_vc_r   <= link.req_vc_id_i;
        end else begin
            s1_flit_r <= s1_flit_r;
            s1_vc_r   <= s1_vc_r;
        end
    end

    // Stage 2 data loads only behind a valid stage 1, so the link holds its last flit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_flit_r <= {FLIT_W{1'b0}};
            s2_vc_r   <= {VC_ID_W{1'b0}};
        end else if (s1_v_r) begin
            s2_flit_r <= s1_flit_r;
            s2_vc_r   <= s1_vc_r;
        end else begin
            s2_flit_r <= s2_flit_r;
            s2_vc_r   <= s2_vc_r;
        end
    end

    // Sticky protocol error: credit overflow or out-of-range return VC.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_r <= 1'b0;
        end else if (ret_bad_s || (|ovf_s)) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign link.req_rdy_o       = rdy_s;
    assign link.tx_flit_pend_o  = s1_v_r;
    assign link.tx_flit_v_o     = s2_v_r;
    assign link.tx_flit_o       = s2_flit_r;
    assign link.tx_flit_vc_id_o = s2_vc_r;
    assign err_o                = err_r;

endmodule
